// File: rtl/rc6_serial_rx.sv
`timescale 1ns/1ps
// rc6_serial_rx
// Input stage of the RC6 datapath. Samples a framed serial stream
// (clk_in / sta_in / data_in) in the clk domain, assembles BLOCK_W bits
// MSB-first and offers the block to the core through a valid/ready handshake.
//
// Ports:
//   clk         system clock, all flops on rising edge
//   reset       synchronous, active-high reset
//   clk_in      serial bit clock from pin (treated as data, edge-detected)
//   sta_in      frame strobe, high for the whole frame
//   data_in     serial data bit
//   data_out    assembled block, first received bit in the MSB
//   data_valid  data_out holds a complete, unconsumed block
//   data_ready  consumer accepts the block when high together with data_valid
//   frame_err   one-cycle pulse when a frame ends before BLOCK_W bits
//   overrun     sticky flag, a completed block was dropped; cleared by reset
module rc6_serial_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int BLOCK_W     = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_in,
    input  logic               sta_in,
    input  logic               data_in,
    output logic [BLOCK_W-1:0] data_out,
    output logic               data_valid,
    input  logic               data_ready,
    output logic               frame_err,
    output logic               overrun
);

    localparam int CNT_W = $clog2(BLOCK_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_W);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECV     = 2'd1,
        LOAD     = 2'd2,
        WAIT_END = 2'd3
    } state_t;

    // Synchroniser chains, one per input pin.
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] sta_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) begin
                        clk_sync_q[gi] <= 1'b0;
                        sta_sync_q[gi] <= 1'b0;
                        dat_sync_q[gi] <= 1'b0;
                    end else begin
                        clk_sync_q[gi] <= clk_in;
                        sta_sync_q[gi] <= sta_in;
                        dat_sync_q[gi] <= data_in;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (reset) begin
                        clk_sync_q[gi] <= 1'b0;
                        sta_sync_q[gi] <= 1'b0;
                        dat_sync_q[gi] <= 1'b0;
                    end else begin
                        clk_sync_q[gi] <= clk_sync_q[gi-1];
                        sta_sync_q[gi] <= sta_sync_q[gi-1];
                        dat_sync_q[gi] <= dat_sync_q[gi-1];
                    end
                end
            end
        end
    endgenerate

    logic clk_s;
    logic sta_s;
    logic data_s;
    logic clk_s_d_q;
    logic sta_s_d_q;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign sta_s  = sta_sync_q[SYNC_STAGES-1];
    assign data_s = dat_sync_q[SYNC_STAGES-1];

    // Tracks which synchroniser stages hold real pin samples since reset.
    // The zeros left in the chain by reset are not a genuine low level, so a
    // frame already running at reset release must not look like a new
    // sta_rise; the top bit says sta_s_d_q is a real sample.
    logic [SYNC_STAGES:0] flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s_d_q <= 1'b0;
            sta_s_d_q <= 1'b0;
            flush_q   <= '0;
        end else begin
            clk_s_d_q <= clk_s;
            sta_s_d_q <= sta_s;
            flush_q   <= {flush_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    logic bit_stb;
    logic sta_rise;
    logic sta_fall;

    assign bit_stb  = clk_s & ~clk_s_d_q;
    assign sta_rise = sta_s & ~sta_s_d_q & flush_q[SYNC_STAGES];
    assign sta_fall = ~sta_s & sta_s_d_q;

    // Frame FSM and datapath.
    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [BLOCK_W-1:0] shift_q,    shift_d;
    logic [BLOCK_W-1:0] data_out_q, data_out_d;
    logic               valid_q,    valid_d;
    logic               err_q,      err_d;
    logic               ovr_q,      ovr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        data_out_d = data_out_q;
        valid_d    = valid_q;
        err_d      = 1'b0;
        ovr_d      = ovr_q;

        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (sta_rise) begin
                    cnt_d   = '0;
                    shift_d = '0;
                    state_d = RECV;
                end
            end
            RECV: begin
                // A full counter takes precedence: the frame is complete even
                // if the strobe drops right after the last bit.
                if (cnt_q == CNT_FULL) begin
                    state_d = LOAD;
                end else if (sta_fall) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (bit_stb && sta_s) begin
                    shift_d = {shift_q[BLOCK_W-2:0], data_s};
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            LOAD: begin
                // The output slot is free if empty or being emptied this cycle.
                if (!valid_q || data_ready) begin
                    data_out_d = shift_q;
                    valid_d    = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
                state_d = WAIT_END;
            end
            WAIT_END: begin
                if (!sta_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_out   = data_out_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_rc6_serial_rx.sv
`timescale 1ns/1ps
// Testbench for rc6_serial_rx: drives framed serial traffic, keeps expected
// blocks in a scoreboard queue and compares them on each accepted handshake.
module tb_rc6_serial_rx;

    localparam int BW = 128;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_in;
    logic          sta_in;
    logic          data_in;
    logic [BW-1:0] data_out;
    logic          data_valid;
    logic          data_ready;
    logic          frame_err;
    logic          overrun;

    always #5 clk = ~clk;

    rc6_serial_rx #(
        .SYNC_STAGES(SS),
        .BLOCK_W    (BW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_in    (clk_in),
        .sta_in    (sta_in),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    int            total = 0;
    int            bad   = 0;
    int            acc_cnt = 0;
    int            err_cycles = 0;
    logic [BW-1:0] sb_q[$];
    logic [BW-1:0] exp_blk;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every accepted block is popped and compared.
    always @(negedge clk) begin
        if (frame_err) err_cycles++;
        if (!reset && data_valid && data_ready) begin
            acc_cnt++;
            if (sb_q.size() == 0) begin
                chk("unexpected_blk", BW'(data_valid), BW'(0));
            end else begin
                exp_blk = sb_q.pop_front();
                chk("blk", data_out, exp_blk);
                $display("accept blk=%h", data_out);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        clk_in  = 1'b0;
        tick(4);
        clk_in  = 1'b1;
        tick(4);
    endtask

    // Sends bit positions from..from+n-1, MSB first; positions past the block are 1s.
    task automatic send_bits(input logic [BW-1:0] v, input int from, input int n);
        for (int i = from; i < from + n; i++) begin
            send_bit(i < BW ? v[BW-1-i] : 1'b1);
        end
    endtask

    task automatic frame_start();
        sta_in = 1'b1;
        tick(4);
    endtask

    task automatic frame_end();
        clk_in = 1'b0;
        tick(4);
        sta_in = 1'b0;
        tick(8);
    endtask

    task automatic wait_valid(input int lim);
        for (int k = 0; k < lim && !data_valid; k++) tick(1);
    endtask

    task automatic full_frame(input logic [BW-1:0] v);
        frame_start();
        send_bits(v, 0, BW);
        frame_end();
    endtask

    logic [BW-1:0] v1, v2, vff, vaa, v55, vone, vdead;
    int lat, e0, a0;

    initial begin
        v1    = 128'h0123456789ABCDEF_FEDCBA9876543210;
        v2    = {4{32'h13579BDF}};
        vff   = '1;
        vaa   = {16{8'hAA}};
        v55   = {16{8'h55}};
        vone  = 128'h1;
        vdead = {4{32'hDEADBEEF}};

        reset = 1'b1; clk_in = 1'b0; sta_in = 1'b0; data_in = 1'b0; data_ready = 1'b0;
        tick(3);
        chk("rst_data_out", data_out, BW'(0));
        chk("rst_valid", BW'(data_valid), BW'(0));
        chk("rst_ferr", BW'(frame_err), BW'(0));
        chk("rst_ovr", BW'(overrun), BW'(0));
        reset = 1'b0;
        tick(2);

        // Basic frame with latency measurement on the last bit.
        data_ready = 1'b1;
        sb_q.push_back(v1);
        e0 = err_cycles;
        frame_start();
        send_bits(v1, 0, BW - 1);
        data_in = v1[0];
        clk_in  = 1'b0;
        tick(4);
        clk_in  = 1'b1;
        lat = 0;
        while (!data_valid && lat < 20) begin
            tick(1);
            lat++;
        end
        chk("basic_latency", BW'(lat), BW'(SS + 3));
        chk("basic_dv_hi", BW'(data_valid), BW'(1));
        tick(1);
        chk("basic_dv_1cyc", BW'(data_valid), BW'(0));
        frame_end();
        chk("basic_ferr", BW'(err_cycles - e0), BW'(0));
        chk("basic_ovr", BW'(overrun), BW'(0));

        // Back-pressure: hold for 20 cycles, then accept.
        data_ready = 1'b0;
        sb_q.push_back(v2);
        frame_start();
        send_bits(v2, 0, BW);
        wait_valid(50);
        chk("bp_dv", BW'(data_valid), BW'(1));
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("bp_hold_dv", BW'(data_valid), BW'(1));
            chk("bp_hold_do", data_out, v2);
        end
        data_ready = 1'b1;
        tick(1);
        chk("bp_dv_drop", BW'(data_valid), BW'(0));
        frame_end();

        // Short frame, then a good all-ones frame.
        e0 = err_cycles;
        frame_start();
        send_bits(v1, 0, 100);
        frame_end();
        chk("short_ferr", BW'(err_cycles - e0), BW'(1));
        chk("short_dv", BW'(data_valid), BW'(0));
        sb_q.push_back(vff);
        full_frame(vff);
        tick(4);

        // Overrun: second frame is dropped, first one retained.
        data_ready = 1'b0;
        sb_q.push_back(vaa);
        full_frame(vaa);
        full_frame(v55);
        chk("ovr_flag", BW'(overrun), BW'(1));
        chk("ovr_kept", data_out, vaa);
        chk("ovr_dv", BW'(data_valid), BW'(1));
        data_ready = 1'b1;
        tick(2);
        chk("ovr_dv_drop", BW'(data_valid), BW'(0));
        chk("ovr_sticky", BW'(overrun), BW'(1));

        // Extra bits inside one strobe window.
        e0 = err_cycles;
        a0 = acc_cnt;
        sb_q.push_back(vone);
        frame_start();
        send_bits(vone, 0, BW + 2);
        frame_end();
        tick(10);
        chk("extra_ferr", BW'(err_cycles - e0), BW'(0));
        chk("extra_one_blk", BW'(acc_cnt - a0), BW'(1));

        // Reset in the middle of a frame.
        e0 = err_cycles;
        a0 = acc_cnt;
        frame_start();
        send_bits(v2, 0, 64);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mid_rst_do", data_out, BW'(0));
        chk("mid_rst_dv", BW'(data_valid), BW'(0));
        chk("mid_rst_ferr", BW'(frame_err), BW'(0));
        chk("mid_rst_ovr", BW'(overrun), BW'(0));
        send_bits(v2, 64, 64);
        frame_end();
        tick(10);
        chk("mid_rst_noerr", BW'(err_cycles - e0), BW'(0));
        chk("mid_rst_noblk", BW'(acc_cnt - a0), BW'(0));
        sb_q.push_back(vdead);
        full_frame(vdead);
        tick(10);

        chk("sb_left", BW'(sb_q.size()), BW'(0));
        chk("accepts", BW'(acc_cnt), BW'(6));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
